l1_data_cache: RTL and testbench

- Blocking, set-associative, write-back, write-allocate L1 data cache.
- Sits between a single CPU load/store port and a block-wide next-level memory port; that port is served by a memory model or by a RAM glue.
- A hit completes combinationally in the request cycle.
- A miss holds miss=1 while it writes back the victim (if dirty) and then fills the block.

---
 rtl/l1_data_cache_pkg.sv | 35 +++
 rtl/l1_data_cache_if.sv | 41 ++++
 rtl/l1_data_cache_lru.sv | 45 ++++
 rtl/l1_data_cache.sv | 214 +++++++++++++++++++++
 tb/tb_l1_data_cache.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_data_cache_pkg.sv
// Shared types and default geometry for the L1 data cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_types;

    localparam int DEF_SIZE   = 1024;
    localparam int DEF_ASSOC  = 2;
    localparam int DEF_BLOCKS = 4;
    localparam int DEF_SETS   = DEF_SIZE / (DEF_ASSOC * DEF_BLOCKS * 4);

    // Address field widths at the default geometry: tag | index | word offset | byte
    localparam int OFFSET_W = $clog2(DEF_BLOCKS);
    localparam int INDEX_W  = $clog2(DEF_SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // One cache line at the default geometry; word 0 sits in the LSBs of data
    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [TAG_W-1:0]           tag;
        logic [DEF_BLOCKS-1:0][31:0] data;
    } line_t;

    // Way-select width that stays at least one bit for a direct-mapped build
    function automatic int way_width(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/l1_data_cache_if.sv
// CPU load/store bus and block-wide next-level memory bus of the L1 data cache.
// Latency: n/a (wiring only). Macro DUAL_PORT_L2_EN splits mem_addr into read/write addresses.
// Backpressure: cpu side stalls on miss; memory side stalls the cache on mem_miss.
interface l1_cpu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byte_mask;
    logic [31:0] write_word;
    logic        miss;
    logic [31:0] read_word;

    modport master (output req, we, addr, byte_mask, write_word, input miss, read_word);
    modport slave  (input req, we, addr, byte_mask, write_word, output miss, read_word);
endinterface

interface l1_mem_if #(parameter int BLOCKS = 4);
    logic                  mem_req;
    logic                  mem_we;
`ifdef DUAL_PORT_L2_EN
    logic [31:0]           mem_read_addr;
    logic [31:0]           mem_write_addr;
`else
    logic [31:0]           mem_addr;
`endif
    logic [BLOCKS*32-1:0]  mem_write_block;
    logic [BLOCKS*32-1:0]  mem_read_block;
    logic                  mem_miss;

`ifdef DUAL_PORT_L2_EN
    modport master (output mem_req, mem_we, mem_read_addr, mem_write_addr, mem_write_block,
                    input mem_read_block, mem_miss);
    modport slave  (input mem_req, mem_we, mem_read_addr, mem_write_addr, mem_write_block,
                    output mem_read_block, mem_miss);
`else
    modport master (output mem_req, mem_we, mem_addr, mem_write_block,
                    input mem_read_block, mem_miss);
    modport slave  (input mem_req, mem_we, mem_addr, mem_write_block,
                    output mem_read_block, mem_miss);
`endif
endinterface

// File: rtl/l1_data_cache_lru.sv
// Per-set true-LRU tracker using per-way age counters (0 = most recently used).
// Latency: touch updates on the next rising edge; victim is combinational from query_set.
// Backpressure: none, accepts a touch every cycle.
module cache_lru #(
    parameter  int SETS  = 32,
    parameter  int ASSOC = 2,
    localparam int SW    = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WW    = (ASSOC > 1) ? $clog2(ASSOC) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          touch,
    input  logic [SW-1:0] touch_set,
    input  logic [WW-1:0] touch_way,
    input  logic [SW-1:0] query_set,
    output logic [WW-1:0] victim_way
);

    logic [WW-1:0] age [SETS][ASSOC];

    // Reset ages so way 0 is oldest; on a touch, age every way younger than the touched one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < ASSOC; w++)
                    age[s][w] <= WW'(ASSOC - 1 - w);
        end else if (touch) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (WW'(w) == touch_way)
                    age[touch_set][w] <= '0;
                else if (age[touch_set][w] < age[touch_set][touch_way])
                    age[touch_set][w] <= age[touch_set][w] + 1'b1;
            end
        end
    end

    // The oldest way of the queried set is the replacement candidate
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < ASSOC; w++)
            if (age[query_set][w] == WW'(ASSOC - 1))
                victim_way = WW'(w);
    end

endmodule

// File: rtl/l1_data_cache.sv
// Blocking set-associative write-back write-allocate L1 data cache (macro DUAL_PORT_L2_EN).
// Latency: hit completes in the request cycle; miss adds one cycle per memory transfer.
// Backpressure: miss=1 stalls the CPU; mem_miss=1 holds the current memory transaction.
module l1_data_cache
    import cache_types::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int ASSOC  = DEF_ASSOC,
    parameter int BLOCKS = DEF_BLOCKS
) (
    input  logic     clock,
    input  logic     reset,
    l1_cpu_if.slave  cpu,
    l1_mem_if.master mem
);

    localparam int SETS  = SIZE / (ASSOC * BLOCKS * 4);
    localparam int OW    = $clog2(BLOCKS);
    localparam int IW    = $clog2(SETS);
    localparam int TW    = 32 - IW - OW - 2;
    localparam int WAY_W = way_width(ASSOC);

    // Line layout follows the instantiated geometry rather than the package default
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TW-1:0]          tag;
        logic [BLOCKS-1:0][31:0] data;
    } set_line_t;

    set_line_t      lines [SETS][ASSOC];
    state_t         state;
    logic [IW-1:0]  lat_index;
    logic [TW-1:0]  lat_tag;
    logic [WAY_W-1:0] lat_way;
`ifdef DUAL_PORT_L2_EN
    logic           lat_wb;
`endif

    logic [IW-1:0]    cur_index;
    logic [TW-1:0]    cur_tag;
    logic [OW-1:0]    cur_off;
    logic             addr_unused;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_way;
    set_line_t        victim_line;
    logic             victim_wb;
    logic             hit_fire;
    logic             start_miss;

    assign cur_index   = cpu.addr[IW+OW+1:OW+2];
    assign cur_tag     = cpu.addr[31:32-TW];
    assign cur_off     = cpu.addr[OW+1:2];
    assign addr_unused = ^cpu.addr[1:0];

    // Tag lookup and victim choice on the live CPU address; lowest way wins ties
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (lines[cur_index][w].valid && lines[cur_index][w].tag == cur_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!lines[cur_index][w].valid) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign victim_way  = inv_any ? inv_way : lru_way;
    assign victim_line = lines[cur_index][victim_way];
    assign victim_wb   = victim_line.valid && victim_line.dirty;
    assign hit_fire    = (state == IDLE) && cpu.req && hit_any;
    assign start_miss  = (state == IDLE) && cpu.req && !hit_any;

    cache_lru #(.SETS(SETS), .ASSOC(ASSOC)) u_lru (
        .clock      (clock),
        .reset      (reset),
        .touch      (hit_fire),
        .touch_set  (cur_index),
        .touch_way  (hit_way),
        .query_set  (cur_index),
        .victim_way (lru_way)
    );

    // Controller: latch the miss context in IDLE, then walk writeback/fill transfers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_index <= '0;
            lat_tag   <= '0;
            lat_way   <= '0;
`ifdef DUAL_PORT_L2_EN
            lat_wb    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_miss) begin
                    lat_index <= cur_index;
                    lat_tag   <= cur_tag;
                    lat_way   <= victim_way;
`ifdef DUAL_PORT_L2_EN
                    lat_wb    <= victim_wb;
                    state     <= ALLOCATE;
`else
                    state     <= victim_wb ? WRITEBACK : ALLOCATE;
`endif
                end
                WRITEBACK: if (!mem.mem_miss) state <= ALLOCATE;
                ALLOCATE:  if (!mem.mem_miss) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Line storage: write hits merge masked bytes, writeback clears dirty, fill installs a clean line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < ASSOC; w++) begin
                    lines[s][w].valid <= 1'b0;
                    lines[s][w].dirty <= 1'b0;
                end
        end else begin
            case (state)
                IDLE: if (hit_fire && cpu.we) begin
                    for (int b = 0; b < 4; b++)
                        if (cpu.byte_mask[b])
                            lines[cur_index][hit_way].data[cur_off][8*b +: 8] <= cpu.write_word[8*b +: 8];
                    lines[cur_index][hit_way].dirty <= 1'b1;
                end
                WRITEBACK: if (!mem.mem_miss) lines[lat_index][lat_way].dirty <= 1'b0;
                ALLOCATE: if (!mem.mem_miss) begin
                    lines[lat_index][lat_way].valid <= 1'b1;
                    lines[lat_index][lat_way].dirty <= 1'b0;
                    lines[lat_index][lat_way].tag   <= lat_tag;
                    lines[lat_index][lat_way].data  <= mem.mem_read_block;
                end
                default: ;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held so an aborted transfer drops at once
    always_comb begin
        cpu.miss            = 1'b0;
        cpu.read_word       = '0;
        mem.mem_req         = 1'b0;
        mem.mem_we          = 1'b0;
        mem.mem_write_block = '0;
`ifdef DUAL_PORT_L2_EN
        mem.mem_read_addr   = '0;
        mem.mem_write_addr  = '0;
`else
        mem.mem_addr        = '0;
`endif
        if (!reset) begin
            case (state)
                IDLE: if (cpu.req) begin
                    if (hit_any) begin
                        cpu.read_word = lines[cur_index][hit_way].data[cur_off];
                    end else begin
                        cpu.miss    = 1'b1;
                        mem.mem_req = 1'b1;
                        mem.mem_we  = victim_wb;
                        if (victim_wb) mem.mem_write_block = victim_line.data;
`ifdef DUAL_PORT_L2_EN
                        mem.mem_read_addr = {cur_tag, cur_index, {(OW+2){1'b0}}};
                        if (victim_wb) mem.mem_write_addr = {victim_line.tag, cur_index, {(OW+2){1'b0}}};
`else
                        mem.mem_addr = victim_wb ? {victim_line.tag, cur_index, {(OW+2){1'b0}}}
                                                 : {cur_tag, cur_index, {(OW+2){1'b0}}};
`endif
                    end
                end
                WRITEBACK: begin
                    cpu.miss            = 1'b1;
                    mem.mem_req         = 1'b1;
                    mem.mem_we          = 1'b1;
                    mem.mem_write_block = lines[lat_index][lat_way].data;
`ifdef DUAL_PORT_L2_EN
                    mem.mem_write_addr  = {lines[lat_index][lat_way].tag, lat_index, {(OW+2){1'b0}}};
`else
                    mem.mem_addr        = {lines[lat_index][lat_way].tag, lat_index, {(OW+2){1'b0}}};
`endif
                end
                ALLOCATE: begin
                    cpu.miss    = 1'b1;
                    mem.mem_req = 1'b1;
`ifdef DUAL_PORT_L2_EN
                    mem.mem_we        = lat_wb;
                    mem.mem_read_addr = {lat_tag, lat_index, {(OW+2){1'b0}}};
                    if (lat_wb) begin
                        mem.mem_write_block = lines[lat_index][lat_way].data;
                        mem.mem_write_addr  = {lines[lat_index][lat_way].tag, lat_index, {(OW+2){1'b0}}};
                    end
`else
                    mem.mem_addr = {lat_tag, lat_index, {(OW+2){1'b0}}};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed bench for l1_data_cache in the default single-port build.
// Memory returns a fixed pattern per block address: word i = 0xD0000000 | (block_addr + 4*i).
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_l1_data_cache;

    logic clock = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clock = ~clock;

    l1_cpu_if cpu ();
    l1_mem_if #(.BLOCKS(4)) mem ();

    l1_data_cache dut (
        .clock (clock),
        .reset (reset),
        .cpu   (cpu),
        .mem   (mem)
    );

    function automatic logic [127:0] fill_pattern(input logic [31:0] a);
        logic [127:0] b;
        for (int i = 0; i < 4; i++)
            b[32*i +: 32] = 32'hD000_0000 | (a + 32'(4 * i));
        return b;
    endfunction

    always_comb mem.mem_read_block = fill_pattern(mem.mem_addr);

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        cpu.req        = 1'b1;
        cpu.we         = w;
        cpu.addr       = a;
        cpu.byte_mask  = m;
        cpu.write_word = d;
    endtask

    // Called at a falling edge; steps cycles until miss drops, bounded
    task automatic wait_done(input string tag);
        int n = 0;
        while (cpu.miss === 1'b1 && n < 20) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        chk1(tag, cpu.miss, 1'b0);
    endtask

    task automatic do_reset();
        cpu.req = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        cpu.req        = 1'b0;
        cpu.we         = 1'b0;
        cpu.addr       = '0;
        cpu.byte_mask  = '0;
        cpu.write_word = '0;
        mem.mem_miss   = 1'b0;
        #2;
        chk1  ("reset miss",        cpu.miss, 1'b0);
        chk1  ("reset mem_req",     mem.mem_req, 1'b0);
        chk1  ("reset mem_we",      mem.mem_we, 1'b0);
        chk32 ("reset mem_addr",    mem.mem_addr, 32'h0);
        chk128("reset write_block", mem.mem_write_block, 128'h0);
        chk32 ("reset read_word",   cpu.read_word, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Cold read of 0x10
        drive(1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clock);
        chk1 ("cold miss",     cpu.miss, 1'b1);
        chk1 ("cold mem_req",  mem.mem_req, 1'b1);
        chk1 ("cold mem_we",   mem.mem_we, 1'b0);
        chk32("cold mem_addr", mem.mem_addr, 32'h10);
        tick();
        @(negedge clock);
        chk32("cold alloc mem_addr", mem.mem_addr, 32'h10);
        wait_done("cold fill done");
        chk32("cold read_word", cpu.read_word, 32'hD000_0010);
        tick();

        // Masked write hit then read back
        drive(1'b1, 32'h14, 4'b0011, 32'hAABB_CCDD);
        @(negedge clock);
        chk1("write hit miss",    cpu.miss, 1'b0);
        chk1("write hit mem_req", mem.mem_req, 1'b0);
        tick();
        drive(1'b0, 32'h14, 4'h0, 32'h0);
        @(negedge clock);
        chk1 ("readback miss", cpu.miss, 1'b0);
        chk32("readback word", cpu.read_word, 32'hD000_CCDD);
        tick();
        drive(1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clock);
        chk32("neighbour word", cpu.read_word, 32'hD000_0010);
        tick();

        // Idle request
        cpu.req = 1'b0;
        @(negedge clock);
        chk1 ("idle miss",      cpu.miss, 1'b0);
        chk1 ("idle mem_req",   mem.mem_req, 1'b0);
        chk32("idle read_word", cpu.read_word, 32'h0);
        tick();

        // Dirty eviction: write 0x000, read 0x200, read 0x400
        do_reset();
        drive(1'b1, 32'h000, 4'hF, 32'h1122_3344);
        @(negedge clock);
        chk1("evict first fill mem_we", mem.mem_we, 1'b0);
        wait_done("evict write fill");
        tick();
        drive(1'b0, 32'h200, 4'h0, 32'h0);
        @(negedge clock);
        chk1 ("evict 0x200 mem_we",   mem.mem_we, 1'b0);
        chk32("evict 0x200 mem_addr", mem.mem_addr, 32'h200);
        wait_done("evict 0x200 fill");
        chk32("evict 0x200 word", cpu.read_word, 32'hD000_0200);
        tick();
        drive(1'b0, 32'h400, 4'h0, 32'h0);
        @(negedge clock);
        chk1  ("evict wb mem_req",  mem.mem_req, 1'b1);
        chk1  ("evict wb mem_we",   mem.mem_we, 1'b1);
        chk32 ("evict wb mem_addr", mem.mem_addr, 32'h000);
        chk128("evict wb block",    mem.mem_write_block,
               128'hD000_000C_D000_0008_D000_0004_1122_3344);
        tick();
        @(negedge clock);
        chk1 ("evict WB state mem_we",   mem.mem_we, 1'b1);
        chk32("evict WB state mem_addr", mem.mem_addr, 32'h000);
        tick();
        @(negedge clock);
        chk1 ("evict fill mem_we",   mem.mem_we, 1'b0);
        chk32("evict fill mem_addr", mem.mem_addr, 32'h400);
        wait_done("evict 0x400 fill");
        chk32("evict 0x400 word", cpu.read_word, 32'hD000_0400);
        tick();

        // LRU on hit: write 0x000, read 0x200, read 0x000, read 0x400
        do_reset();
        drive(1'b1, 32'h000, 4'hF, 32'h1122_3344);
        @(negedge clock);
        wait_done("lru write fill");
        tick();
        drive(1'b0, 32'h200, 4'h0, 32'h0);
        @(negedge clock);
        wait_done("lru 0x200 fill");
        tick();
        drive(1'b0, 32'h000, 4'h0, 32'h0);
        @(negedge clock);
        chk1 ("lru hit miss", cpu.miss, 1'b0);
        chk32("lru hit word", cpu.read_word, 32'h1122_3344);
        tick();
        drive(1'b0, 32'h400, 4'h0, 32'h0);
        @(negedge clock);
        chk1 ("lru victim mem_we",   mem.mem_we, 1'b0);
        chk32("lru victim mem_addr", mem.mem_addr, 32'h400);
        tick();
        @(negedge clock);
        chk1 ("lru alloc mem_we",   mem.mem_we, 1'b0);
        chk32("lru alloc mem_addr", mem.mem_addr, 32'h400);
        wait_done("lru 0x400 fill");
        tick();
        drive(1'b0, 32'h000, 4'h0, 32'h0);
        @(negedge clock);
        chk1("lru 0x000 retained", cpu.miss, 1'b0);
        tick();

        // Slow memory: fill held off for five cycles
        mem.mem_miss = 1'b1;
        drive(1'b0, 32'h30, 4'h0, 32'h0);
        @(negedge clock);
        chk1("slow first miss", cpu.miss, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clock);
            chk1 ("slow miss",     cpu.miss, 1'b1);
            chk1 ("slow mem_req",  mem.mem_req, 1'b1);
            chk1 ("slow mem_we",   mem.mem_we, 1'b0);
            chk32("slow mem_addr", mem.mem_addr, 32'h30);
        end
        mem.mem_miss = 1'b0;
        wait_done("slow fill done");
        chk32("slow word", cpu.read_word, 32'hD000_0030);
        tick();

        // Reset during ALLOCATE aborts the fill and invalidates everything
        mem.mem_miss = 1'b1;
        drive(1'b0, 32'h50, 4'h0, 32'h0);
        tick();
        @(negedge clock);
        chk1("abort pre mem_req", mem.mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("abort mem_req", mem.mem_req, 1'b0);
        chk1("abort miss",    cpu.miss, 1'b0);
        tick();
        mem.mem_miss = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk1 ("abort re-miss",     cpu.miss, 1'b1);
        chk32("abort re-mem_addr", mem.mem_addr, 32'h50);
        wait_done("abort refill");
        tick();
        drive(1'b0, 32'h30, 4'h0, 32'h0);
        @(negedge clock);
        chk1("invalidated 0x30 miss", cpu.miss, 1'b1);
        wait_done("0x30 refill");
        chk32("0x30 refill word", cpu.read_word, 32'hD000_0030);
        tick();
        cpu.req = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
